// File: rtl/threadbrain_pkg.sv
// rtl/threadbrain_pkg.sv - shared instruction-word widths, opcode field and opcode constants
package threadbrain_pkg;

    localparam int INS_W   = 16;
    localparam int ADDR_W  = 16;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;

    typedef enum logic [3:0] {
        OPC_NOP  = 4'h0,
        OPC_ALU  = 4'h1,
        OPC_LD   = 4'h2,
        OPC_ST   = 4'h3,
        OPC_BR   = 4'h4,
        OPC_JMP  = 4'h5,
        OPC_FORK = 4'h6,
        OPC_JOIN = 4'h7
    } opcode_e;

    function automatic logic is_fork(input logic [INS_W-1:0] ins);
        return ins[OPC_MSB:OPC_LSB] == OPC_FORK;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, registered last-grant pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 gnt_any_o
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Search starts one past the last winner so every requester is reached within N grants.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IDX_W'((int'(last_q) + off) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
            end
        end
        gnt_any_o = found;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IDX_W'(N - 1);
        end else if (gnt_any_o) begin
            last_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/ins_fetch_arb.sv
// rtl/ins_fetch_arb.sv - shares one instruction memory among NCORES cores, one fetch per cycle
module ins_fetch_arb
    import threadbrain_pkg::*;
#(
    parameter int NCORES  = 4,
    parameter int MEM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORES-1:0]        core_ens,
    input  logic [NCORES-1:0]        core_reqs,
    input  logic [NCORES*ADDR_W-1:0] core_pcs,
    output logic [NCORES-1:0]        core_grants,
    output logic                     imem_en,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INS_W-1:0]         imem_data,
    output logic [INS_W-1:0]         ins_out,
    output logic                     ins_valid,
    output logic [3:0]               ins_core,
    output logic [NCORES-1:0]        core_ins_valid,
    output logic                     fork_hit
);
    localparam int IDX_W = $clog2(NCORES);

    if (MEM_LAT != 1 || NCORES < 2 || NCORES > 16) begin : g_param_check
        $error("ins_fetch_arb: unsupported NCORES or MEM_LAT");
    end

    logic [NCORES-1:0] pending_q, pending_d, eligible, gnt, clr;
    logic [IDX_W-1:0]  gnt_idx, grant_idx_q, mem_core_q;
    logic              gnt_any, mem_v_q, deliver;
    logic [ADDR_W-1:0] pc_sel;

    logic [NCORES-1:0] core_grants_q, core_ins_valid_q;
    logic              imem_en_q, ins_valid_q, fork_hit_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [INS_W-1:0]  ins_out_q;
    logic [3:0]        ins_core_q;

    assign eligible = core_reqs & core_ens & ~pending_q;

    rr_arbiter #(.N(NCORES)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (eligible),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    always_comb begin
        pc_sel = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (gnt[i]) pc_sel = core_pcs[i*ADDR_W +: ADDR_W];
        end
    end

    // The capture stage retires the owner's pending bit whether the fetch is delivered or dropped.
    assign clr       = mem_v_q ? (NCORES'(1) << mem_core_q) : '0;
    assign deliver   = mem_v_q & core_ens[mem_core_q];
    assign pending_d = (pending_q & ~clr) | gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q        <= '0;
            core_grants_q    <= '0;
            imem_en_q        <= 1'b0;
            imem_addr_q      <= '0;
            grant_idx_q      <= '0;
            mem_v_q          <= 1'b0;
            mem_core_q       <= '0;
            ins_out_q        <= '0;
            ins_valid_q      <= 1'b0;
            ins_core_q       <= '0;
            core_ins_valid_q <= '0;
            fork_hit_q       <= 1'b0;
        end else begin
            pending_q     <= pending_d;
            core_grants_q <= gnt;
            imem_en_q     <= gnt_any;
            if (gnt_any) begin
                imem_addr_q <= pc_sel;
                grant_idx_q <= gnt_idx;
            end
            mem_v_q          <= imem_en_q;
            mem_core_q       <= grant_idx_q;
            ins_valid_q      <= deliver;
            core_ins_valid_q <= deliver ? clr : '0;
            fork_hit_q       <= deliver & is_fork(imem_data);
            if (deliver) begin
                ins_out_q  <= imem_data;
                ins_core_q <= 4'(mem_core_q);
            end
        end
    end

    assign core_grants    = core_grants_q;
    assign imem_en        = imem_en_q;
    assign imem_addr      = imem_addr_q;
    assign ins_out        = ins_out_q;
    assign ins_valid      = ins_valid_q;
    assign ins_core       = ins_core_q;
    assign core_ins_valid = core_ins_valid_q;
    assign fork_hit       = fork_hit_q;

endmodule
